// File: rtl/mini_input_cond_if.sv
// Signal bundle between the raw-input environment and the mini_input_cond
// conditioner: raw levels and glitch clear in, clean levels/pulses/status out.
interface mini_input_cond_if;
    logic       raw_x1;
    logic       raw_x2;
    logic       raw_x3;
    logic       glitch_clr;
    logic       x1;
    logic       x2;
    logic       x3;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       stable;
    logic [7:0] glitch_cnt;

    modport master (
        output raw_x1, raw_x2, raw_x3, glitch_clr,
        input  x1, x2, x3, rise, fall, stable, glitch_cnt
    );

    modport slave (
        input  raw_x1, raw_x2, raw_x3, glitch_clr,
        output x1, x2, x3, rise, fall, stable, glitch_cnt
    );
endinterface

// File: rtl/mini_input_cond.sv
// Input conditioner feeding the mini register stage: three raw asynchronous
// levels are synchronized, debounced per channel, and presented as clean
// registered levels with one-cycle rise/fall pulses. Rejected glitches are
// tallied in a saturating debug counter.
module mini_input_cond #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic            clk,
    input logic            reset,
    mini_input_cond_if.slave io
);
    localparam int unsigned CW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {IDLE, PEND} ch_state_t;

    logic [2:0]             raw;
    logic [2:0]             s;
    logic [SYNC_STAGES-1:0] sync_q [3];
    ch_state_t              state_q [3];
    ch_state_t              state_d [3];
    logic [CW-1:0]          cnt_q [3];
    logic [CW-1:0]          cnt_d [3];
    logic [2:0]             x_q, x_d;
    logic [2:0]             rise_q, rise_d;
    logic [2:0]             fall_q, fall_d;
    logic [2:0]             glitch_ev;
    logic [2:0]             in_idle;
    logic [7:0]             glitch_cnt_q, glitch_cnt_d;
    logic [8:0]             glitch_sum;

    assign raw = {io.raw_x3, io.raw_x2, io.raw_x1};

    // Per-channel synchronizer chains; last stage is the debouncer sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 3; i++) sync_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        end
    end

    // Pick out the synchronized samples and per-channel idle flags.
    always_comb begin
        s       = '0;
        in_idle = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            s[i]       = sync_q[i][SYNC_STAGES-1];
            in_idle[i] = (state_q[i] == IDLE);
        end
    end

    // Debounce next-state: a new level must persist DEBOUNCE_CYCLES samples.
    always_comb begin
        logic accept;
        x_d       = x_q;
        rise_d    = '0;
        fall_d    = '0;
        glitch_ev = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            accept     = 1'b0;
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (s[i] != x_q[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d[i] = PEND;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                PEND: begin
                    if (s[i] == x_q[i]) begin
                        glitch_ev[i] = 1'b1;
                        state_d[i]   = IDLE;
                        cnt_d[i]     = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            if (accept) begin
                x_d[i]     = s[i];
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end
        end
    end

    // Debounce state, output levels and edge pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            x_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            x_q    <= x_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Saturating glitch tally; clear takes priority over same-edge events.
    always_comb begin
        glitch_sum = {1'b0, glitch_cnt_q} + 9'(glitch_ev[0]) + 9'(glitch_ev[1]) + 9'(glitch_ev[2]);
        if (io.glitch_clr)
            glitch_cnt_d = '0;
        else if (glitch_sum[8])
            glitch_cnt_d = '1;
        else
            glitch_cnt_d = glitch_sum[7:0];
    end

    // Glitch counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) glitch_cnt_q <= '0;
        else        glitch_cnt_q <= glitch_cnt_d;
    end

    assign io.x1         = x_q[0];
    assign io.x2         = x_q[1];
    assign io.x3         = x_q[2];
    assign io.rise       = rise_q;
    assign io.fall       = fall_q;
    assign io.stable     = &in_idle;
    assign io.glitch_cnt = glitch_cnt_q;
endmodule

// File: tb/tb_mini_input_cond.sv
// Bench for mini_input_cond: three instances (defaults, SYNC=3/DEB=1,
// SYNC=2/DEB=255) share one stimulus and are tracked by a run-length model.
module tb_mini_input_cond;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] raw;
    logic       clr;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    mini_input_cond_if if0 ();
    mini_input_cond_if if1 ();
    mini_input_cond_if if2 ();

    assign if0.raw_x1 = raw[0];
    assign if0.raw_x2 = raw[1];
    assign if0.raw_x3 = raw[2];
    assign if0.glitch_clr = clr;
    assign if1.raw_x1 = raw[0];
    assign if1.raw_x2 = raw[1];
    assign if1.raw_x3 = raw[2];
    assign if1.glitch_clr = clr;
    assign if2.raw_x1 = raw[0];
    assign if2.raw_x2 = raw[1];
    assign if2.raw_x3 = raw[2];
    assign if2.glitch_clr = clr;

    mini_input_cond #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4))   dut0 (.clk(clk), .reset(rst_n), .io(if0));
    mini_input_cond #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1))   dut1 (.clk(clk), .reset(rst_n), .io(if1));
    mini_input_cond #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(255)) dut2 (.clk(clk), .reset(rst_n), .io(if2));

    logic [2:0] dx [3];
    logic [2:0] drise [3];
    logic [2:0] dfall [3];
    logic       dst [3];
    logic [7:0] dgl [3];

    assign dx[0] = {if0.x3, if0.x2, if0.x1};
    assign dx[1] = {if1.x3, if1.x2, if1.x1};
    assign dx[2] = {if2.x3, if2.x2, if2.x1};
    assign drise[0] = if0.rise;
    assign drise[1] = if1.rise;
    assign drise[2] = if2.rise;
    assign dfall[0] = if0.fall;
    assign dfall[1] = if1.fall;
    assign dfall[2] = if2.fall;
    assign dst[0] = if0.stable;
    assign dst[1] = if1.stable;
    assign dst[2] = if2.stable;
    assign dgl[0] = if0.glitch_cnt;
    assign dgl[1] = if1.glitch_cnt;
    assign dgl[2] = if2.glitch_cnt;

    function automatic int unsigned msync(int k);
        return (k == 1) ? 3 : 2;
    endfunction

    function automatic int unsigned mdeb(int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 255);
    endfunction

    // Reference model: raw delayed SYNC edges, then a run of DEB differing
    // samples flips the level; a run cut short is one glitch.
    bit [3:0]    hist [3][3];
    int unsigned run [3][3];
    bit [2:0]    mx [3];
    bit [2:0]    mrise [3];
    bit [2:0]    mfall [3];
    bit          mst [3];
    int unsigned mgl [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < 3; c++) begin
                    hist[k][c] = '0;
                    run[k][c]  = 0;
                end
                mx[k] = '0; mrise[k] = '0; mfall[k] = '0; mst[k] = 1'b1; mgl[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int unsigned ev;
                ev = 0;
                mst[k] = 1'b1;
                mrise[k] = '0;
                mfall[k] = '0;
                for (int c = 0; c < 3; c++) begin
                    bit smp;
                    smp = hist[k][c][msync(k)-1];
                    hist[k][c] = {hist[k][c][2:0], raw[c]};
                    if (smp != mx[k][c]) begin
                        run[k][c]++;
                        if (run[k][c] >= mdeb(k)) begin
                            mx[k][c] = smp;
                            mrise[k][c] = smp;
                            mfall[k][c] = !smp;
                            run[k][c] = 0;
                        end
                    end else begin
                        if (run[k][c] != 0) ev++;
                        run[k][c] = 0;
                    end
                    if (run[k][c] != 0) mst[k] = 1'b0;
                end
                if (clr) mgl[k] = 0;
                else mgl[k] = (mgl[k] + ev > 255) ? 255 : mgl[k] + ev;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        raw = 3'b111;
        repeat (8) tick();
        raw = 3'b000;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (dx[k] !== 3'b000) $display("FAIL reset_x[%0d] got %b want 000", k, dx[k]); else n_pass++;
            n_total++; if (drise[k] !== 3'b000) $display("FAIL reset_rise[%0d] got %b want 000", k, drise[k]); else n_pass++;
            n_total++; if (dfall[k] !== 3'b000) $display("FAIL reset_fall[%0d] got %b want 000", k, dfall[k]); else n_pass++;
            n_total++; if (dgl[k] !== 8'd0) $display("FAIL reset_glitch[%0d] got %0d want 0", k, dgl[k]); else n_pass++;
            n_total++; if (dst[k] !== 1'b1) $display("FAIL reset_stable[%0d] got %b want 1", k, dst[k]); else n_pass++;
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                n_total++; if (dx[k] !== 3'b000) $display("FAIL post_reset_x[%0d] got %b want 000", k, dx[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_clean_step();
        raw = 3'b000;
        repeat (12) tick();
        raw = 3'b010;
        for (int n = 0; n < 8; n++) begin
            tick();
            n_total++; if (dx[0] !== ((n >= 5) ? 3'b010 : 3'b000)) $display("FAIL step_x edge %0d got %b", n, dx[0]); else n_pass++;
            n_total++; if (drise[0] !== ((n == 5) ? 3'b010 : 3'b000)) $display("FAIL step_rise edge %0d got %b", n, drise[0]); else n_pass++;
            n_total++; if (dst[0] !== !(n >= 2 && n <= 4)) $display("FAIL step_stable edge %0d got %b", n, dst[0]); else n_pass++;
        end
        raw = 3'b000;
        repeat (12) tick();
    endtask

    task automatic test_glitch();
        int highs, rises, falls;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_total++; if (dgl[0] !== 8'd0) $display("FAIL glitch_clr got %0d want 0", dgl[0]); else n_pass++;
        highs = 0;
        for (int n = 0; n < 16; n++) begin
            raw[0] = (n < 3);
            tick();
            if (dx[0][0]) highs++;
        end
        n_total++; if (highs != 0) $display("FAIL glitch3_x1 high for %0d cycles want 0", highs); else n_pass++;
        n_total++; if (dgl[0] !== 8'd1) $display("FAIL glitch3_count got %0d want 1", dgl[0]); else n_pass++;
        highs = 0; rises = 0; falls = 0;
        for (int n = 0; n < 20; n++) begin
            raw[0] = (n < 4);
            tick();
            if (dx[0][0]) highs++;
            if (drise[0][0]) rises++;
            if (dfall[0][0]) falls++;
        end
        n_total++; if (highs != 4) $display("FAIL pulse4_x1 high for %0d cycles want 4", highs); else n_pass++;
        n_total++; if (rises != 1 || falls != 1) $display("FAIL pulse4_edges rise %0d fall %0d want 1/1", rises, falls); else n_pass++;
        n_total++; if (dgl[0] !== 8'd1) $display("FAIL pulse4_count got %0d want 1", dgl[0]); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int changes;
        logic [7:0] prev;
        raw = 3'b111;
        for (int n = 0; n < 8; n++) begin
            tick();
            n_total++; if (dx[0] !== ((n >= 5) ? 3'b111 : 3'b000)) $display("FAIL simul_x edge %0d got %b", n, dx[0]); else n_pass++;
            n_total++; if (drise[0] !== ((n == 5) ? 3'b111 : 3'b000)) $display("FAIL simul_rise edge %0d got %b", n, drise[0]); else n_pass++;
        end
        raw = 3'b000;
        repeat (12) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        prev = 8'd0;
        changes = 0;
        for (int n = 0; n < 12; n++) begin
            raw = (n < 2) ? 3'b111 : 3'b000;
            tick();
            if (dgl[0] !== prev) changes++;
            prev = dgl[0];
        end
        n_total++; if (dgl[0] !== 8'd3) $display("FAIL simul_glitch got %0d want 3", dgl[0]); else n_pass++;
        n_total++; if (changes != 1) $display("FAIL simul_glitch_edges got %0d want 1", changes); else n_pass++;
    endtask

    task automatic test_saturation();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int r = 0; r < 100; r++) begin
            raw = 3'b111;
            tick();
            raw = 3'b000;
            repeat (4) tick();
        end
        n_total++; if (dgl[0] !== 8'd255) $display("FAIL saturate got %0d want 255", dgl[0]); else n_pass++;
        raw[0] = 1'b1;
        tick();
        raw[0] = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        n_total++; if (dgl[0] !== 8'd0) $display("FAIL clr_wins got %0d want 0", dgl[0]); else n_pass++;
        tick();
        n_total++; if (dgl[0] !== 8'd0) $display("FAIL clr_hold got %0d want 0", dgl[0]); else n_pass++;
    endtask

    task automatic test_corners();
        int highs, rises;
        raw = 3'b000;
        repeat (300) tick();
        raw = 3'b100;
        for (int n = 0; n < 6; n++) begin
            tick();
            n_total++; if (dx[1][2] !== (n >= 3)) $display("FAIL deb1_step edge %0d got %b", n, dx[1][2]); else n_pass++;
            n_total++; if (drise[1] !== ((n == 3) ? 3'b100 : 3'b000)) $display("FAIL deb1_rise edge %0d got %b", n, drise[1]); else n_pass++;
        end
        raw = 3'b000;
        repeat (8) tick();
        highs = 0; rises = 0;
        for (int n = 0; n < 10; n++) begin
            raw[2] = (n == 0);
            tick();
            if (dx[1][2]) highs++;
            if (drise[1][2]) rises++;
        end
        n_total++; if (highs != 1 || rises != 1) $display("FAIL deb1_pulse high %0d rise %0d want 1/1", highs, rises); else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        highs = 0;
        for (int n = 0; n < 300; n++) begin
            raw[0] = (n < 254);
            tick();
            if (dx[2][0]) highs++;
        end
        n_total++; if (highs != 0) $display("FAIL deb255_reject high %0d want 0", highs); else n_pass++;
        n_total++; if (dgl[2] !== 8'd1) $display("FAIL deb255_glitch got %0d want 1", dgl[2]); else n_pass++;
        highs = 0;
        for (int n = 0; n < 600; n++) begin
            raw[0] = (n < 255);
            tick();
            if (dx[2][0]) highs++;
        end
        n_total++; if (highs != 255) $display("FAIL deb255_pass high %0d want 255", highs); else n_pass++;
    endtask

    task automatic test_random();
        int hold [3];
        for (int c = 0; c < 3; c++) hold[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    raw[c] = ~raw[c];
                    hold[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 300)) : int'($urandom_range(1, 6));
                end
                hold[c]--;
            end
            clr = ($urandom_range(0, 63) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_total++; if (dx[k] !== mx[k]) $display("FAIL rand_x[%0d] cyc %0d got %b want %b", k, n, dx[k], mx[k]); else n_pass++;
                n_total++; if (drise[k] !== mrise[k]) $display("FAIL rand_rise[%0d] cyc %0d got %b want %b", k, n, drise[k], mrise[k]); else n_pass++;
                n_total++; if (dfall[k] !== mfall[k]) $display("FAIL rand_fall[%0d] cyc %0d got %b want %b", k, n, dfall[k], mfall[k]); else n_pass++;
                n_total++; if (dst[k] !== mst[k]) $display("FAIL rand_stable[%0d] cyc %0d got %b want %b", k, n, dst[k], mst[k]); else n_pass++;
                n_total++; if (dgl[k] !== 8'(mgl[k])) $display("FAIL rand_glitch[%0d] cyc %0d got %0d want %0d", k, n, dgl[k], mgl[k]); else n_pass++;
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        raw = 3'b000;
        clr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_clean_step();
        test_glitch();
        test_simultaneous();
        test_saturation();
        test_corners();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
